// File: rtl/bus_reader_pkg.sv
// Shared types and constants for the bus_reader sequencer and the register-bank top.
// Optional scan mode is enabled by defining BUS_READER_SCAN_EN.
package bus_reader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StTurn,
        StDrive,
        StResp
    } state_e;

    localparam int unsigned CntWidth     = 3;
    localparam int unsigned DefaultNsrc  = 4;
    localparam int unsigned DefaultWidth = 32;

endpackage

// File: rtl/bus_reader_if.sv
// Request/response handshake plus shared-bus enables between a requester and bus_reader.
interface bus_reader_if
    import bus_reader_pkg::*;
#(
    parameter int unsigned NSRC  = DefaultNsrc,
    parameter int unsigned WIDTH = DefaultWidth
);
    localparam int unsigned SELW = $clog2(NSRC);

    logic             req_valid;
    logic             req_ready;
    logic [SELW-1:0]  req_sel;
    logic             req_scan;
    logic [NSRC-1:0]  enable_out;
    logic [WIDTH-1:0] bus_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [SELW-1:0]  rsp_src;
    logic             rsp_err;
    logic             rsp_last;

    modport slave (
        input  req_valid, req_sel, req_scan, bus_in, rsp_ready,
        output req_ready, enable_out, rsp_valid, rsp_data, rsp_src, rsp_err, rsp_last
    );

    modport master (
        output req_valid, req_sel, req_scan, bus_in, rsp_ready,
        input  req_ready, enable_out, rsp_valid, rsp_data, rsp_src, rsp_err, rsp_last
    );

endinterface

// File: rtl/bus_sel_decode.sv
// Index-to-one-hot decoder; all-zero when disabled or when the index is out of range.
module bus_sel_decode #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned SELW = $clog2(NSRC)
) (
    input  logic [SELW-1:0] sel,
    input  logic            en,
    output logic [NSRC-1:0] onehot
);

    // Out-of-range indices simply never match any bit position.
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            onehot[i] = en && (sel == SELW'(i));
        end
    end

endmodule

// File: rtl/bus_reader.sv
// Read sequencer for the shared tristate register bus: turnaround, one-hot enable, capture.
// Define BUS_READER_SCAN_EN to enable scan mode (read every source in order).
module bus_reader
    import bus_reader_pkg::*;
#(
    parameter int unsigned NSRC  = DefaultNsrc,
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned TURN  = 1
) (
    input  logic          clk,
    input  logic          reset,
    bus_reader_if.slave   bus
);

    localparam int unsigned SELW = $clog2(NSRC);
    localparam logic [CntWidth-1:0] TurnLast = CntWidth'(TURN - 1);

    state_e               state_q;
    logic [CntWidth-1:0]  cnt_q;
    logic [SELW-1:0]      sel_q;
    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic [WIDTH-1:0]     rsp_data_q;
    logic [SELW-1:0]      rsp_src_q;
    logic                 rsp_err_q;
    logic                 sel_ok;
    logic                 more;
    logic [NSRC-1:0]      enable;

    assign sel_ok = 32'(sel_q) < NSRC;

`ifdef BUS_READER_SCAN_EN
    localparam logic [SELW-1:0] LastSel = SELW'(NSRC - 1);
    logic scan_q;
    logic rsp_last_q;

    assign more = scan_q && (sel_q != LastSel);
    assign bus.rsp_last = rsp_last_q;
`else
    logic unused_req_scan;

    assign unused_req_scan = bus.req_scan;
    assign more = 1'b0;
    assign bus.rsp_last = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sel_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_src_q   <= '0;
            rsp_err_q   <= 1'b0;
`ifdef BUS_READER_SCAN_EN
            scan_q      <= 1'b0;
            rsp_last_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= StTurn;
`ifdef BUS_READER_SCAN_EN
                        scan_q      <= bus.req_scan;
                        sel_q       <= bus.req_scan ? '0 : bus.req_sel;
`else
                        sel_q       <= bus.req_sel;
`endif
                    end
                end
                StTurn: begin
                    if (cnt_q == TurnLast) begin
                        if (sel_ok) begin
                            state_q <= StDrive;
                        end else begin
                            // No source behind this index: answer with an error, never drive.
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_src_q   <= sel_q;
                            rsp_err_q   <= 1'b1;
`ifdef BUS_READER_SCAN_EN
                            rsp_last_q  <= !more;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDrive: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= bus.bus_in;
                    rsp_src_q   <= sel_q;
                    rsp_err_q   <= 1'b0;
`ifdef BUS_READER_SCAN_EN
                    rsp_last_q  <= !more;
`endif
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (more) begin
                            sel_q   <= sel_q + 1'b1;
                            cnt_q   <= '0;
                            state_q <= StTurn;
                        end else begin
                            req_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Decoded from registered state only, so reset clears it without waiting for a clock.
    bus_sel_decode #(
        .NSRC (NSRC),
        .SELW (SELW)
    ) u_decode (
        .sel    (sel_q),
        .en     (state_q == StDrive),
        .onehot (enable)
    );

    assign bus.enable_out = enable;
    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_src    = rsp_src_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule
